// File: rtl/move_director_if.sv
// Director-side signal bundle: keyboard input, sprite position, maze ROM port and direction command.
// The director takes the master view; the keyboard, mover and ROM side take the slave view.
interface move_director_if;
    logic [7:0] keycode;
    logic       key_valid;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic [5:0] tile_col;
    logic [4:0] tile_row;
    logic       tile_rd;
    logic       tile_wall;
    logic [2:0] direction;

    modport master (
        input  keycode, key_valid, pos_x, pos_y, tile_wall,
        output tile_col, tile_row, tile_rd, direction
    );

    modport slave (
        output keycode, key_valid, pos_x, pos_y, tile_wall,
        input  tile_col, tile_row, tile_rd, direction
    );
endinterface

// File: rtl/move_director.sv
// Buffers the last arrow key and commits it to the {move, dir} command only when the maze allows it;
// the decision lands 4 + 2*ROM_LAT cycles after tick detection at worst, and there is no backpressure.
module move_director #(
    parameter int TILE_LOG2 = 4,
    parameter int MAZE_COLS = 40,
    parameter int MAZE_ROWS = 30,
    parameter int ROM_LAT   = 1
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Restart,
    input  logic frame_clk,
    move_director_if.master bus
);
    localparam int COL_W  = 10 - TILE_LOG2;
    localparam int ROW_W  = 10 - TILE_LOG2;
    localparam int WAIT_W = (ROM_LAT > 0) ? $clog2(ROM_LAT + 1) : 1;

    typedef enum logic [2:0] {IDLE, Q_PEND, W_PEND, Q_CUR, W_CUR} state_t;

    state_t             r_state;
    logic [WAIT_W-1:0]  r_wait;
    logic               r_frame_clk_d;
    logic               r_tick;
    logic               r_move;
    logic [1:0]         r_dir;
    logic               r_pend_v;
    logic [1:0]         r_pend_d;
    logic               r_new_key;
    logic [COL_W-1:0]   r_snap_col;
    logic [ROW_W-1:0]   r_snap_row;
    logic [1:0]         r_snap_d;
    logic [5:0]         r_tile_col;
    logic [4:0]         r_tile_row;
    logic               r_tile_rd;

    logic               w_key_hit;
    logic [1:0]         w_key_dir;
    logic               w_aligned;

    always_comb begin
        w_key_hit = bus.key_valid;
        w_key_dir = 2'd0;
        case (bus.keycode)
            8'h1D:   w_key_dir = 2'd0;
            8'h23:   w_key_dir = 2'd1;
            8'h1B:   w_key_dir = 2'd2;
            8'h1C:   w_key_dir = 2'd3;
            default: w_key_hit = 1'b0;
        endcase
    end

    assign w_aligned = (bus.pos_x[TILE_LOG2-1:0] == '0) && (bus.pos_y[TILE_LOG2-1:0] == '0);

    // Neighbour tile with toroidal wrap; >= keeps an out-of-range column from running off the maze.
    function automatic logic [5:0] f_nb_col(input logic [COL_W-1:0] c, input logic [1:0] d);
        logic [5:0] n;
        n = 6'(c);
        if (d == 2'd1)
            n = (c >= COL_W'(MAZE_COLS - 1)) ? 6'd0 : 6'(c + COL_W'(1));
        else if (d == 2'd3)
            n = (c == '0) ? 6'(MAZE_COLS - 1) : 6'(c - COL_W'(1));
        return n;
    endfunction

    function automatic logic [4:0] f_nb_row(input logic [ROW_W-1:0] r, input logic [1:0] d);
        logic [4:0] n;
        n = 5'(r);
        if (d == 2'd2)
            n = (r >= ROW_W'(MAZE_ROWS - 1)) ? 5'd0 : 5'(r + ROW_W'(1));
        else if (d == 2'd0)
            n = (r == '0) ? 5'(MAZE_ROWS - 1) : 5'(r - ROW_W'(1));
        return n;
    endfunction

    always_ff @(posedge Clk) begin
        r_frame_clk_d <= frame_clk;
        if (Reset || Restart) begin
            r_state    <= IDLE;
            r_wait     <= '0;
            r_tick     <= 1'b0;
            r_move     <= 1'b0;
            r_dir      <= 2'd0;
            r_pend_v   <= 1'b0;
            r_pend_d   <= 2'd0;
            r_new_key  <= 1'b0;
            r_snap_col <= '0;
            r_snap_row <= '0;
            r_snap_d   <= 2'd0;
            r_tile_col <= 6'd0;
            r_tile_row <= 5'd0;
            r_tile_rd  <= 1'b0;
        end else begin
            r_tick    <= frame_clk & ~r_frame_clk_d;
            r_tile_rd <= 1'b0;
            r_new_key <= r_new_key | w_key_hit;

            case (r_state)
                IDLE: begin
                    if (r_tick) begin
                        if (!w_aligned) begin
                            // Mid-tile only a straight reversal is safe: the tile behind is known open.
                            if (r_pend_v && r_move && (r_pend_d == (r_dir ^ 2'b10))) begin
                                r_dir    <= r_pend_d;
                                r_pend_v <= 1'b0;
                            end
                        end else begin
                            r_snap_col <= bus.pos_x[9:TILE_LOG2];
                            r_snap_row <= bus.pos_y[9:TILE_LOG2];
                            r_snap_d   <= r_pend_d;
                            r_new_key  <= w_key_hit;
                            if (r_pend_v)
                                r_state <= Q_PEND;
                            else if (r_move)
                                r_state <= Q_CUR;
                        end
                    end
                end
                Q_PEND: begin
                    r_tile_col <= f_nb_col(r_snap_col, r_snap_d);
                    r_tile_row <= f_nb_row(r_snap_row, r_snap_d);
                    r_tile_rd  <= 1'b1;
                    r_wait     <= WAIT_W'(ROM_LAT);
                    r_state    <= W_PEND;
                end
                W_PEND: begin
                    if (r_wait != '0) begin
                        r_wait <= r_wait - WAIT_W'(1);
                    end else if (!bus.tile_wall) begin
                        r_move   <= 1'b1;
                        r_dir    <= r_snap_d;
                        r_pend_v <= r_new_key;
                        r_state  <= IDLE;
                    end else begin
                        r_state <= r_move ? Q_CUR : IDLE;
                    end
                end
                Q_CUR: begin
                    r_tile_col <= f_nb_col(r_snap_col, r_dir);
                    r_tile_row <= f_nb_row(r_snap_row, r_dir);
                    r_tile_rd  <= 1'b1;
                    r_wait     <= WAIT_W'(ROM_LAT);
                    r_state    <= W_CUR;
                end
                W_CUR: begin
                    if (r_wait != '0) begin
                        r_wait <= r_wait - WAIT_W'(1);
                    end else begin
                        if (bus.tile_wall)
                            r_move <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // A fresh key always overrides any clearing of the pending turn above.
            if (w_key_hit) begin
                r_pend_v <= 1'b1;
                r_pend_d <= w_key_dir;
            end
        end
    end

    assign bus.tile_col  = r_tile_col;
    assign bus.tile_row  = r_tile_row;
    assign bus.tile_rd   = r_tile_rd;
    assign bus.direction = {r_move, r_dir};
endmodule
